// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port combinational Memory array between two requesters:
// requester 0 (instruction fetch) and requester 1 (data load/store).
// Ties are broken round-robin. The granted request is registered, so the
// Memory control, address and data lines are stable for the whole access
// window. Each completed access returns a one-cycle ack.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req0/we0/addr0/wdata0    requester 0 request, write enable, address, data
//   ack0/rdata0              requester 0 completion pulse and read data
//   req1/we1/addr1/wdata1    requester 1 request, write enable, address, data
//   ack1/rdata1              requester 1 completion pulse and read data
//   memAddress/memWriteData  registered address and write data to Memory
//   memRead/memWrite         Memory strobes, high only during ACCESS
//   memReadData              combinational read data from Memory
//   busy                     high in ACCESS and ACK
//   grantId                  owner of the current or most recent transaction
module mem_port_arbiter #(
  parameter int WORD          = 8,
  parameter int ADDRESSL      = 5,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                we0,
  input  logic [ADDRESSL-1:0] addr0,
  input  logic [WORD-1:0]     wdata0,
  output logic                ack0,
  output logic [WORD-1:0]     rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [ADDRESSL-1:0] addr1,
  input  logic [WORD-1:0]     wdata1,
  output logic                ack1,
  output logic [WORD-1:0]     rdata1,
  output logic [ADDRESSL-1:0] memAddress,
  output logic [WORD-1:0]     memWriteData,
  output logic                memRead,
  output logic                memWrite,
  input  logic [WORD-1:0]     memReadData,
  output logic                busy,
  output logic                grantId
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // The counter is loaded with ACCESS_CYCLES-1 so the strobes stay high
  // for exactly ACCESS_CYCLES cycles (zero means "last cycle of the window").
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t                r_state;
  state_t                w_nextState;
  logic                  w_grant;
  logic                  w_winner;
  logic                  r_lastGrant;
  logic                  r_grantId;
  logic                  r_we;
  logic [3:0]            r_cnt;
  logic [ADDRESSL-1:0]   r_memAddress;
  logic [WORD-1:0]       r_memWriteData;
  logic [WORD-1:0]       r_rdata0;
  logic [WORD-1:0]       r_rdata1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and arbitration. With both requesters waiting, the one that
  // did not win last time gets the memory, so neither can starve.
  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_winner    = r_lastGrant;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_grant     = 1'b1;
          w_nextState = ACCESS;
          if (req0 && req1) begin
            w_winner = ~r_lastGrant;
          end else begin
            w_winner = req1;
          end
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_nextState = ACK;
        end
      end
      ACK: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. The winner's request is latched on the grant edge; later
  // changes on the request inputs have no effect on the running access.
  // Address and write data are only reloaded on a grant so they never
  // glitch between transactions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lastGrant    <= 1'b1;
      r_grantId      <= 1'b0;
      r_we           <= 1'b0;
      r_cnt          <= 4'd0;
      r_memAddress   <= '0;
      r_memWriteData <= '0;
      r_rdata0       <= '0;
      r_rdata1       <= '0;
    end else if (w_grant) begin
      r_grantId      <= w_winner;
      r_lastGrant    <= w_winner;
      r_cnt          <= CNT_INIT;
      r_we           <= w_winner ? we1 : we0;
      r_memAddress   <= w_winner ? addr1 : addr0;
      r_memWriteData <= w_winner ? wdata1 : wdata0;
    end else if (r_state == ACCESS) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (!r_we) begin
        if (r_grantId) begin
          r_rdata1 <= memReadData;
        end else begin
          r_rdata0 <= memReadData;
        end
      end
    end
  end

  // Strobes and acks are decoded from registers only, so no request input
  // can reach the Memory lines combinationally.
  assign memRead      = (r_state == ACCESS) && !r_we;
  assign memWrite     = (r_state == ACCESS) && r_we;
  assign ack0         = (r_state == ACK) && !r_grantId;
  assign ack1         = (r_state == ACK) && r_grantId;
  assign busy         = (r_state != IDLE);
  assign grantId      = r_grantId;
  assign memAddress   = r_memAddress;
  assign memWriteData = r_memWriteData;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives two arbiter instances: one with the default one-cycle access window
// and one with a three-cycle window. Each has its own Memory model. The
// default instance also runs a randomized sequence that is compared against
// a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, memRead, memWrite, busy, grantId;
  logic [7:0] rdata0, rdata1, memWriteData, memReadData;
  logic [4:0] memAddress;

  logic       en3;
  logic       ack0Slow, ack1Slow, memReadSlow, memWriteSlow, busySlow, grantIdSlow;
  logic [7:0] rdata0Slow, rdata1Slow, memWriteDataSlow, memReadDataSlow;
  logic [4:0] memAddressSlow;

  logic [7:0] mem [32];
  logic [7:0] mm [32];

  int checks;
  int errors;
  int who;
  logic       lg, win;
  logic       p0, p1;
  logic       rw0, rw1;
  logic [4:0] ra0, ra1;
  logic [7:0] rd0, rd1;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memRead(memRead), .memWrite(memWrite), .memReadData(memReadData),
    .busy(busy), .grantId(grantId)
  );

  // The slow instance only sees requests while its own test phase runs.
  mem_port_arbiter #(.ACCESS_CYCLES(3)) dutSlow (
    .clk(clk), .rst(rst),
    .req0(req0 & en3), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0Slow), .rdata0(rdata0Slow),
    .req1(req1 & en3), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1Slow), .rdata1(rdata1Slow),
    .memAddress(memAddressSlow), .memWriteData(memWriteDataSlow),
    .memRead(memReadSlow), .memWrite(memWriteSlow), .memReadData(memReadDataSlow),
    .busy(busySlow), .grantId(grantIdSlow)
  );

  function automatic logic [7:0] initVal(input logic [4:0] a);
    return {3'b000, a} * 8'd7 + 8'd3;
  endfunction

  // Memory for the default instance: combinational read, write on a clock
  // edge while memWrite is high.
  assign memReadData = mem[memAddress];
  always @(posedge clk) begin
    if (memWrite) mem[memAddress] <= memWriteData;
  end

  // The slow instance only ever reads, so its memory is its initial contents.
  assign memReadDataSlow = initVal(memAddressSlow);

  // Immediate-assertion comparison; counts every check and every failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives every requester input in one step.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [4:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [4:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // Waits a bounded number of cycles for an ack on the default instance and
  // returns the acked requester, or 2 if none arrived.
  task automatic waitAck(output int acked);
    acked = 2;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        checkOutput("ack_onehot", 64'(ack0 & ack1), 64'(0));
        acked = ack1 ? 1 : 0;
        break;
      end
    end
  endtask

  // Directed phases followed by a randomized phase and the slow-window phase.
  initial begin
    checks = 0;
    errors = 0;
    en3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = initVal(5'(i));
      mm[i]  = initVal(5'(i));
    end

    // Reset held with both requests pending: nothing may be granted.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd10, 8'h00, 1'b1, 1'b0, 5'd20, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 64'({ack0, ack1, rdata0, rdata1, memAddress, memWriteData,
                                      memRead, memWrite, busy, grantId}), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("first_grant_id", 64'(grantId), 64'(0));
    checkOutput("first_grant_busy", 64'(busy), 64'(1));
    checkOutput("first_grant_read", 64'(memRead), 64'(1));
    checkOutput("first_grant_addr", 64'(memAddress), 64'(10));

    // Contention: both held for four transactions, grants alternate from 0.
    for (int k = 0; k < 4; k++) begin
      waitAck(who);
      checkOutput("cont_order", 64'(who), 64'(k % 2));
      if (who == 0) checkOutput("cont_rdata0", 64'(rdata0), 64'(mm[10]));
      if (who == 1) checkOutput("cont_rdata1", 64'(rdata1), 64'(mm[20]));
      if (k == 3) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
      @(negedge clk);
      checkOutput("cont_ack_single", 64'({ack0, ack1}), 64'(0));
    end

    // Requester 1 writes A5 to address 7, then reads it back.
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b1, 5'd7, 8'hA5);
    @(negedge clk);
    checkOutput("wr_memWrite", 64'(memWrite), 64'(1));
    checkOutput("wr_memRead", 64'(memRead), 64'(0));
    checkOutput("wr_addr", 64'(memAddress), 64'(7));
    checkOutput("wr_data", 64'(memWriteData), 64'(8'hA5));
    checkOutput("wr_grantId", 64'(grantId), 64'(1));
    waitAck(who);
    mm[7] = 8'hA5;
    checkOutput("wr_ack_id", 64'(who), 64'(1));
    checkOutput("wr_ack_memWrite", 64'(memWrite), 64'(0));
    checkOutput("wr_ack_busy", 64'(busy), 64'(1));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 5'd7, 8'h00);
    @(negedge clk);
    checkOutput("idle_busy", 64'(busy), 64'(0));
    checkOutput("idle_addr_hold", 64'(memAddress), 64'(7));
    checkOutput("idle_ack", 64'({ack0, ack1}), 64'(0));
    @(negedge clk);
    checkOutput("rd_memRead", 64'(memRead), 64'(1));
    waitAck(who);
    checkOutput("rd_ack_id", 64'(who), 64'(1));
    checkOutput("rd_rdata1", 64'(rdata1), 64'(mm[7]));
    checkOutput("rd_mem7", 64'(mem[7]), 64'(mm[7]));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);

    // Address and data changed after the grant edge must be ignored.
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h5A, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 5'd9, 8'hFF, 1'b0, 1'b0, 5'd0, 8'h00);
    checkOutput("pert_addr", 64'(memAddress), 64'(2));
    checkOutput("pert_data", 64'(memWriteData), 64'(8'h5A));
    checkOutput("pert_memWrite", 64'(memWrite), 64'(1));
    waitAck(who);
    mm[2] = 8'h5A;
    checkOutput("pert_ack_id", 64'(who), 64'(0));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    checkOutput("pert_mem2", 64'(mem[2]), 64'(mm[2]));
    checkOutput("pert_mem9", 64'(mem[9]), 64'(mm[9]));

    // Randomized traffic against the transaction-level model. The model only
    // knows the rules: a lone request wins, a tie goes to the requester that
    // did not win last, reads return memory contents, writes update them.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lg = 1'b1;
    p0 = 1'b0;
    p1 = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!p0 && ($urandom_range(0, 1) == 1)) begin
        p0 = 1'b1; rw0 = 1'($urandom); ra0 = 5'($urandom); rd0 = 8'($urandom);
      end
      if (!p1 && (($urandom_range(0, 1) == 1) || !p0)) begin
        p1 = 1'b1; rw1 = 1'($urandom); ra1 = 5'($urandom); rd1 = 8'($urandom);
      end
      applyStimulus(p0, rw0, ra0, rd0, p1, rw1, ra1, rd1);
      win = (p0 && p1) ? ~lg : p1;
      waitAck(who);
      checkOutput("rnd_ack_id", 64'(who), 64'(win));
      if (!win && !rw0) checkOutput("rnd_rdata0", 64'(rdata0), 64'(mm[ra0]));
      if (win && !rw1) checkOutput("rnd_rdata1", 64'(rdata1), 64'(mm[ra1]));
      if (!win && rw0) mm[ra0] = rd0;
      if (win && rw1) mm[ra1] = rd1;
      lg = win;
      if (win) p1 = 1'b0; else p0 = 1'b0;
      applyStimulus(p0, rw0, ra0, rd0, p1, rw1, ra1, rd1);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      if (mem[i] !== mm[i]) checkOutput("rnd_mem_contents", 64'(mem[i]), 64'(mm[i]));
    end
    checkOutput("rnd_mem_sample", 64'(mem[ra0]), 64'(mm[ra0]));

    // Reset during a write drops the strobe at once and suppresses the ack.
    applyStimulus(1'b1, 1'b1, 5'd4, 8'h33, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    checkOutput("mid_memWrite_before", 64'(memWrite), 64'(1));
    rst = 1'b0;
    #1;
    checkOutput("mid_memWrite_async", 64'(memWrite), 64'(0));
    checkOutput("mid_busy_async", 64'(busy), 64'(0));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_no_ack", 64'({ack0, ack1}), 64'(0));
    checkOutput("mid_idle", 64'(busy), 64'(0));
    applyStimulus(1'b1, 1'b0, 5'd1, 8'h00, 1'b1, 1'b0, 5'd2, 8'h00);
    @(negedge clk);
    checkOutput("mid_tie_grant", 64'(grantId), 64'(0));
    waitAck(who);
    checkOutput("mid_tie_ack", 64'(who), 64'(0));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);

    // Three-cycle access window on the slow instance.
    en3 = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("slow_memRead", 64'(memReadSlow), 64'(1));
      checkOutput("slow_addr", 64'(memAddressSlow), 64'(3));
      checkOutput("slow_no_ack_yet", 64'(ack0Slow), 64'(0));
    end
    @(negedge clk);
    checkOutput("slow_ack0", 64'(ack0Slow), 64'(1));
    checkOutput("slow_memRead_off", 64'(memReadSlow), 64'(0));
    checkOutput("slow_rdata0", 64'(rdata0Slow), 64'(initVal(5'd3)));
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
    en3 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
